// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the memory stage: opcodes, load/store funct3 codes, FSM states.
package rv32_pkg;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } mem_state_e;

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic addr_aligned(logic [2:0] funct3, logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~addr_lo[0];
      default: return addr_lo == 2'b00;
    endcase
  endfunction

  function automatic logic writes_rd(logic [6:0] opc);
    case (opc)
      OpcOp, OpcOpImm, OpcLui, OpcAuipc, OpcJal, OpcJalr: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_align.sv
// Combinational store lane steering and load data extraction.
module mem_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_result_o
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    if (is_store_i) begin
      case (funct3_i)
        F3Sb: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        F3Sh: begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (addr_lo_i)
      2'b00:   load_byte = load_data_i[7:0];
      2'b01:   load_byte = load_data_i[15:8];
      2'b10:   load_byte = load_data_i[23:16];
      default: load_byte = load_data_i[31:24];
    endcase
    load_half = addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];

    case (funct3_i)
      F3Lb:    load_result_o = {{24{load_byte[7]}}, load_byte};
      F3Lbu:   load_result_o = {24'h0, load_byte};
      F3Lh:    load_result_o = {{16{load_half[15]}}, load_half};
      F3Lhu:   load_result_o = {16'h0, load_half};
      default: load_result_o = load_data_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32 memory stage: issues one data-memory access at a time, stalls upstream while waiting,
// aborts on timeout and forwards non-memory results to writeback.
module mem_access
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rstl,
  input  logic [10:0]  opcode_exe_2_mem_i,
  input  logic [4:0]   rd_exe_2_mem_i,
  input  logic [31:0]  rd_data_exe_2_mem_i,
  input  logic [31:0]  mem_data_i,
  input  logic         load_valid_i,
  input  logic         store_valid_i,
  mem_access_if.master dmem,
  output logic         wb_valid_o,
  output logic [4:0]   rd_mem_2_wb_o,
  output logic [31:0]  rd_data_mem_2_wb_o,
  output logic         stall_mem_o,
  output logic         misaligned_o,
  output logic         bus_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [4:0]      rd_q, rd_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      rd_wb_q, rd_wb_d;
  logic [31:0]     rd_data_wb_q, rd_data_wb_d;
  logic            misaligned_q, misaligned_d;
  logic            bus_err_q, bus_err_d;

  logic        unused_funct7;
  logic [2:0]  f3_in;
  logic        mem_req;
  logic        req_aligned;
  logic        timeout_hit;
  logic [2:0]  align_f3;
  logic [1:0]  align_lo;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] load_result;

  assign unused_funct7 = opcode_exe_2_mem_i[10];
  assign f3_in         = opcode_exe_2_mem_i[9:7];
  assign mem_req       = load_valid_i | store_valid_i;
  assign req_aligned   = addr_aligned(f3_in, rd_data_exe_2_mem_i[1:0]);
  assign timeout_hit   = cnt_q == CntW'(TIMEOUT_CYCLES - 1);

  // Idle: steer the incoming store; Access: extract with the captured load attributes.
  assign align_f3 = (state_q == StAccess) ? f3_q : f3_in;
  assign align_lo = (state_q == StAccess) ? addr_lo_q : rd_data_exe_2_mem_i[1:0];

  mem_align u_mem_align (
    .funct3_i      (align_f3),
    .addr_lo_i     (align_lo),
    .is_store_i    (store_valid_i & ~load_valid_i),
    .store_data_i  (mem_data_i),
    .load_data_i   (dmem.rdata),
    .be_o          (align_be),
    .wdata_o       (align_wdata),
    .load_result_o (load_result)
  );

  always_ff @(posedge clk) begin
    if (rstl) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      f3_q         <= '0;
      addr_lo_q    <= '0;
      rd_q         <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      wb_valid_q   <= 1'b0;
      rd_wb_q      <= '0;
      rd_data_wb_q <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      addr_lo_q    <= addr_lo_d;
      rd_q         <= rd_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      wb_valid_q   <= wb_valid_d;
      rd_wb_q      <= rd_wb_d;
      rd_data_wb_q <= rd_data_wb_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (mem_req && req_aligned) state_d = StAccess;
      StAccess: if (dmem.ack || timeout_hit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    addr_lo_d    = addr_lo_q;
    rd_d         = rd_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    wb_valid_d   = 1'b0;
    rd_wb_d      = rd_wb_q;
    rd_data_wb_d = rd_data_wb_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (mem_req) begin
          f3_d      = f3_in;
          addr_lo_d = rd_data_exe_2_mem_i[1:0];
          rd_d      = rd_exe_2_mem_i;
          if (req_aligned) begin
            req_d   = 1'b1;
            we_d    = ~load_valid_i;
            addr_d  = {rd_data_exe_2_mem_i[31:2], 2'b00};
            wdata_d = align_wdata;
            be_d    = align_be;
            cnt_d   = '0;
          end else begin
            misaligned_d = 1'b1;
          end
        end else begin
          rd_wb_d      = rd_exe_2_mem_i;
          rd_data_wb_d = rd_data_exe_2_mem_i;
          wb_valid_d   = writes_rd(opcode_exe_2_mem_i[6:0]) && (rd_exe_2_mem_i != 5'd0);
        end
      end
      StAccess: begin
        if (dmem.ack) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (!we_q) begin
            rd_wb_d      = rd_q;
            rd_data_wb_d = load_result;
            wb_valid_d   = rd_q != 5'd0;
          end
        end else if (timeout_hit) begin
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign dmem.req           = req_q;
  assign dmem.we            = we_q;
  assign dmem.addr          = addr_q;
  assign dmem.wdata         = wdata_q;
  assign dmem.be            = be_q;
  assign wb_valid_o         = wb_valid_q;
  assign rd_mem_2_wb_o      = rd_wb_q;
  assign rd_data_mem_2_wb_o = rd_data_wb_q;
  assign stall_mem_o        = state_q == StAccess;
  assign misaligned_o       = misaligned_q;
  assign bus_err_o          = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment, timeout, pass-through, reset.
module tb_mem_access;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcOp    = 7'b0110011;

  logic        clk;
  logic        rstl;
  logic [10:0] opcode;
  logic [4:0]  rd_exe;
  logic [31:0] rd_data_exe;
  logic [31:0] mem_data;
  logic        load_valid;
  logic        store_valid;
  logic        wb_valid;
  logic [4:0]  rd_wb;
  logic [31:0] rd_data_wb;
  logic        stall;
  logic        misaligned;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_if dmem_bus ();

  mem_access #(
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clk                 (clk),
    .rstl                (rstl),
    .opcode_exe_2_mem_i  (opcode),
    .rd_exe_2_mem_i      (rd_exe),
    .rd_data_exe_2_mem_i (rd_data_exe),
    .mem_data_i          (mem_data),
    .load_valid_i        (load_valid),
    .store_valid_i       (store_valid),
    .dmem                (dmem_bus),
    .wb_valid_o          (wb_valid),
    .rd_mem_2_wb_o       (rd_wb),
    .rd_data_mem_2_wb_o  (rd_data_wb),
    .stall_mem_o         (stall),
    .misaligned_o        (misaligned),
    .bus_err_o           (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    opcode      = '0;
    rd_exe      = '0;
    rd_data_exe = '0;
    mem_data    = '0;
    load_valid  = 1'b0;
    store_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic exp_wb);
    int stalls = 0;
    dmem_bus.ack = 1'b0;
    opcode       = {1'b0, f3, OpcLoad};
    rd_exe       = rd;
    rd_data_exe  = addr;
    load_valid   = 1'b1;
    @(negedge clk);
    idle_inputs();
    check({tag, "_addr"}, dmem_bus.addr, {addr[31:2], 2'b00});
    check({tag, "_be"}, {28'h0, dmem_bus.be}, 32'hF);
    check({tag, "_we"}, {31'h0, dmem_bus.we}, 32'h0);
    for (int c = 0; c < 20; c++) begin
      if (!stall) break;
      stalls++;
      dmem_bus.ack   = (stalls == waits + 1);
      dmem_bus.rdata = rdata;
      @(negedge clk);
    end
    dmem_bus.ack = 1'b0;
    check({tag, "_stalls"}, stalls, waits + 1);
    check({tag, "_wbv"}, {31'h0, wb_valid}, {31'h0, exp_wb});
    if (exp_wb) begin
      check({tag, "_data"}, rd_data_wb, exp_data);
      check({tag, "_rd"}, {27'h0, rd_wb}, {27'h0, rd});
    end
    @(negedge clk);
    check({tag, "_wbpulse"}, {31'h0, wb_valid}, 32'h0);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
    dmem_bus.ack = 1'b0;
    opcode       = {1'b0, f3, OpcStore};
    rd_data_exe  = addr;
    mem_data     = data;
    store_valid  = 1'b1;
    @(negedge clk);
    idle_inputs();
    check({tag, "_req"}, {31'h0, dmem_bus.req}, 32'h1);
    check({tag, "_we"}, {31'h0, dmem_bus.we}, 32'h1);
    check({tag, "_addr"}, dmem_bus.addr, {addr[31:2], 2'b00});
    check({tag, "_be"}, {28'h0, dmem_bus.be}, {28'h0, exp_be});
    check({tag, "_wdata"}, dmem_bus.wdata, exp_wdata);
    check({tag, "_stall"}, {31'h0, stall}, 32'h1);
    dmem_bus.ack = 1'b1;
    @(negedge clk);
    dmem_bus.ack = 1'b0;
    check({tag, "_reqdone"}, {31'h0, dmem_bus.req}, 32'h0);
    check({tag, "_nowb"}, {31'h0, wb_valid}, 32'h0);
    check({tag, "_unstall"}, {31'h0, stall}, 32'h0);
  endtask

  initial begin
    int req_cnt;
    logic seen_req;

    idle_inputs();
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = '0;
    rstl           = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", {31'h0, dmem_bus.req}, 32'h0);
    check("rst_we", {31'h0, dmem_bus.we}, 32'h0);
    check("rst_addr", dmem_bus.addr, 32'h0);
    check("rst_wdata", dmem_bus.wdata, 32'h0);
    check("rst_be", {28'h0, dmem_bus.be}, 32'h0);
    check("rst_wbv", {31'h0, wb_valid}, 32'h0);
    check("rst_rd", {27'h0, rd_wb}, 32'h0);
    check("rst_data", rd_data_wb, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_mis", {31'h0, misaligned}, 32'h0);
    check("rst_berr", {31'h0, bus_err}, 32'h0);
    rstl = 1'b0;

    // ALU pass-through, then rd=0 suppresses writeback.
    opcode = {1'b0, 3'b000, OpcOp}; rd_exe = 5'd5; rd_data_exe = 32'h1234;
    @(negedge clk);
    check("add_wbv", {31'h0, wb_valid}, 32'h1);
    check("add_rd", {27'h0, rd_wb}, 32'd5);
    check("add_data", rd_data_wb, 32'h1234);
    rd_exe = 5'd0;
    @(negedge clk);
    check("add_rd0_wbv", {31'h0, wb_valid}, 32'h0);
    idle_inputs();
    @(negedge clk);

    run_store("sb", 3'b000, 32'h1003, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    run_store("sh", 3'b001, 32'h1002, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    run_store("sw", 3'b010, 32'h1004, 32'h12345678, 4'b1111, 32'h12345678);

    run_load("lb", 3'b000, 32'h2002, 5'd7, 3, 32'h0080FF00, 32'hFFFFFF80, 1'b1);
    run_load("lbu", 3'b100, 32'h2002, 5'd7, 3, 32'h0080FF00, 32'h00000080, 1'b1);
    run_load("lh", 3'b001, 32'h2000, 5'd8, 0, 32'h12348001, 32'hFFFF8001, 1'b1);
    run_load("lhu", 3'b101, 32'h2000, 5'd8, 1, 32'h12348001, 32'h00008001, 1'b1);
    run_load("lw", 3'b010, 32'h2004, 5'd31, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    run_load("lw_rd0", 3'b010, 32'h2004, 5'd0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

    // Misaligned halfword load never touches the bus.
    opcode = {1'b0, 3'b001, OpcLoad}; rd_exe = 5'd4; rd_data_exe = 32'h3001; load_valid = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("mis_pulse", {31'h0, misaligned}, 32'h1);
    check("mis_wbv", {31'h0, wb_valid}, 32'h0);
    check("mis_stall", {31'h0, stall}, 32'h0);
    seen_req = dmem_bus.req;
    @(negedge clk);
    check("mis_pulse_end", {31'h0, misaligned}, 32'h0);
    repeat (3) begin
      seen_req |= dmem_bus.req;
      @(negedge clk);
    end
    check("mis_noreq", {31'h0, seen_req}, 32'h0);

    // Both valids: the load wins.
    dmem_bus.ack = 1'b0;
    opcode = {1'b0, 3'b010, OpcLoad}; rd_exe = 5'd6; rd_data_exe = 32'h2008;
    load_valid = 1'b1; store_valid = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("both_we", {31'h0, dmem_bus.we}, 32'h0);
    dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_bus.ack = 1'b0;
    check("both_wbv", {31'h0, wb_valid}, 32'h1);
    check("both_data", rd_data_wb, 32'hCAFEF00D);

    // Stray ack while idle.
    dmem_bus.ack = 1'b1;
    @(negedge clk);
    dmem_bus.ack = 1'b0;
    check("idle_ack_wbv", {31'h0, wb_valid}, 32'h0);
    check("idle_ack_req", {31'h0, dmem_bus.req}, 32'h0);

    // Timeout on an unanswered word load.
    opcode = {1'b0, 3'b010, OpcLoad}; rd_exe = 5'd9; rd_data_exe = 32'h2010; load_valid = 1'b1;
    @(negedge clk);
    idle_inputs();
    req_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!dmem_bus.req) break;
      req_cnt++;
      @(negedge clk);
    end
    check("to_reqcycles", req_cnt, 16);
    check("to_berr", {31'h0, bus_err}, 32'h1);
    check("to_wbv", {31'h0, wb_valid}, 32'h0);
    check("to_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    check("to_berr_end", {31'h0, bus_err}, 32'h0);

    // Reset in the second access cycle, ack arrives afterwards.
    opcode = {1'b0, 3'b010, OpcLoad}; rd_exe = 5'd3; rd_data_exe = 32'h2000; load_valid = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("rsta_req1", {31'h0, dmem_bus.req}, 32'h1);
    @(negedge clk);
    rstl = 1'b1;
    @(negedge clk);
    rstl = 1'b0;
    dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h55AA55AA;
    check("rsta_req", {31'h0, dmem_bus.req}, 32'h0);
    check("rsta_stall", {31'h0, stall}, 32'h0);
    check("rsta_addr", dmem_bus.addr, 32'h0);
    @(negedge clk);
    dmem_bus.ack = 1'b0;
    check("rsta_wbv", {31'h0, wb_valid}, 32'h0);
    check("rsta_req_post", {31'h0, dmem_bus.req}, 32'h0);
    check("rsta_data", rd_data_wb, 32'h0);
    check("rsta_stall_post", {31'h0, stall}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
